// File: rtl/a_key_collector.sv
// ============================================================================
// Module   : a_key_collector
// Brief    : Keypad digit collector: gathers a 4-digit BCD code, submits it on
//            enter, and supports clear/backspace, idle timeout and lockout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module a_key_collector #(
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid_i,
    input  logic [3:0]  key_code_i,
    input  logic        gen_stop_i,
    input  logic        gen_rst_i,
    output logic [15:0] pw_16bit_o,
    output logic        enough_o,
    output logic        disable_cnt_o,
    output logic [2:0]  digit_cnt_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_FULL   = 3'd2;
    localparam logic [2:0] S_SUBMIT = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    localparam int              TMR_W    = 27;
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] K_CLEAR = 4'hA;
    localparam logic [3:0] K_ENTER = 4'hB;
    localparam logic [3:0] K_BKSP  = 4'hC;

    logic [2:0]       state_q, state_d;
    logic [15:0]      pw_q, pw_d;
    logic [2:0]       digit_q, digit_d;
    logic             enough_q, enough_d;
    logic             disable_q, disable_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic w_key_ev;
    logic w_is_digit;
    logic w_editable;
    logic w_counting;
    logic w_key_accept;
    logic w_timeout;
    logic w_take_digit;
    logic w_take_bksp;

    // Reserved codes never count as key events, so they cannot restart the timer.
    assign w_key_ev     = key_valid_i && (key_code_i <= K_BKSP);
    assign w_is_digit   = (key_code_i <= 4'h9);
    assign w_editable   = (state_q == S_IDLE) || (state_q == S_ENTRY) || (state_q == S_FULL);
    assign w_counting   = (state_q == S_ENTRY) || (state_q == S_FULL);
    assign w_key_accept = w_key_ev && !gen_stop_i && !gen_rst_i && w_editable;
    assign w_timeout    = w_counting && (tmr_q == TMR_LAST);
    assign w_take_digit = w_key_accept && w_is_digit &&
                          ((state_q == S_IDLE) || (state_q == S_ENTRY));
    assign w_take_bksp  = w_key_accept && (key_code_i == K_BKSP) && w_counting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pw_q      <= 16'h0000;
            digit_q   <= 3'd0;
            enough_q  <= 1'b0;
            disable_q <= 1'b1;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pw_q      <= pw_d;
            digit_q   <= digit_d;
            enough_q  <= enough_d;
            disable_q <= disable_d;
            tmr_q     <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gen_stop_i) begin
            state_d = S_LOCKED;
        end else begin
            case (state_q)
                S_LOCKED: state_d = S_IDLE;
                S_SUBMIT: if (gen_rst_i) state_d = S_IDLE;
                S_IDLE, S_ENTRY, S_FULL: begin
                    if (gen_rst_i) begin
                        state_d = S_IDLE;
                    end else if (w_key_ev) begin
                        if (w_is_digit) begin
                            if (state_q != S_FULL)
                                state_d = (digit_q == 3'd3) ? S_FULL : S_ENTRY;
                        end else if (key_code_i == K_CLEAR) begin
                            state_d = S_IDLE;
                        end else if (key_code_i == K_ENTER) begin
                            state_d = (state_q == S_FULL) ? S_SUBMIT : S_IDLE;
                        end else if (state_q != S_IDLE) begin
                            state_d = (digit_q == 3'd1) ? S_IDLE : S_ENTRY;
                        end
                    end else if (w_timeout) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // IDLE and LOCKED always hold an empty entry, so the target state alone
    // decides when the code and count are wiped.
    always_comb begin
        pw_d      = pw_q;
        digit_d   = digit_q;
        if ((state_d == S_IDLE) || (state_d == S_LOCKED)) begin
            pw_d    = 16'h0000;
            digit_d = 3'd0;
        end else if (w_take_digit) begin
            pw_d    = {pw_q[11:0], key_code_i};
            digit_d = digit_q + 3'd1;
        end else if (w_take_bksp) begin
            pw_d    = {4'h0, pw_q[15:4]};
            digit_d = digit_q - 3'd1;
        end
        enough_d  = (state_d == S_SUBMIT);
        disable_d = (state_d != S_SUBMIT);

        tmr_d = tmr_q;
        if ((state_d != state_q) || w_key_accept)
            tmr_d = '0;
        else if (w_counting && (tmr_q != TMR_MAX))
            tmr_d = tmr_q + 1'b1;
    end

    assign pw_16bit_o    = pw_q;
    assign digit_cnt_o   = digit_q;
    assign enough_o      = enough_q;
    assign disable_cnt_o = disable_q;

endmodule

`default_nettype wire

// File: doc/a_key_collector.md
A_KEY_COLLECTOR -- requirements
Module: a_key_collector

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 100000000, meaning idle cycles allowed between key events before a partial entry is discarded.
REQ-002 clk  input  1  The single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 key_valid  input  1  Single-cycle strobe indicating that key_code is valid; the input is already debounced.
REQ-005 key_code  input  4  Key code: 0x0-0x9 digit, 0xA clear, 0xB enter, 0xC backspace, 0xD-0xF reserved.
REQ-006 gen_stop  input  1  Lockout request from the checker/error side; it is level-sensitive.
REQ-007 gen_rst  input  1  Request from the checker to clear a submitted entry; it is a one-cycle pulse.
REQ-008 pw_16bit  output  16  Entered code, four BCD nibbles, with the most recent digit in [3:0].
REQ-009 enough  output  1  High while a complete 4-digit entry is submitted.
REQ-010 disable_cnt  output  1  High whenever no submission is pending, so that the checker does not count errors.
REQ-011 digit_cnt  output  3  Number of digits held, 0-4.

Function
REQ-012 The FSM SHALL have the states IDLE, ENTRY, FULL, SUBMIT and LOCKED, and all outputs SHALL be registered.
REQ-013 Priority each cycle SHALL be: gen_stop > gen_rst > key event > timeout.
REQ-014 gen_stop=1 in any state SHALL cause the next state to be LOCKED, with pw_16bit=0, digit_cnt=0 and enough=0.
REQ-015 LOCKED SHALL ignore all keys and gen_rst, and SHALL go to IDLE on the first cycle gen_stop=0.
REQ-016 A digit in IDLE or ENTRY SHALL cause pw_16bit<={pw_16bit[11:0],key_code} and digit_cnt+1, with the new value visible on the cycle after the strobe.
REQ-017 A digit taking digit_cnt to 4 SHALL cause the next state to be FULL; otherwise the next state SHALL be ENTRY.
REQ-018 Digits received in FULL SHALL be ignored (no shift, no count change).
REQ-019 Backspace in ENTRY or FULL SHALL cause pw_16bit<={4'h0,pw_16bit[15:4]} and digit_cnt-1.
REQ-020 When backspace takes digit_cnt to 0 the next state SHALL be IDLE; otherwise it SHALL be ENTRY.
REQ-021 Backspace in IDLE SHALL have no effect, and digit_cnt SHALL never underflow.
REQ-022 Clear in IDLE, ENTRY or FULL SHALL set pw_16bit=0 and digit_cnt=0, and the next state SHALL be IDLE.
REQ-023 Enter in FULL SHALL cause the next state to be SUBMIT, with enough=1 and disable_cnt=0 from the next cycle onward.
REQ-024 Enter in IDLE or ENTRY (short entry) SHALL discard the entry (same effect as clear) and SHALL NOT assert enough.
REQ-025 In SUBMIT, pw_16bit SHALL be frozen, and all keys and the timeout SHALL be ignored.
REQ-026 gen_rst in SUBMIT SHALL cause the next state to be IDLE, with pw_16bit=0, digit_cnt=0, enough=0 and disable_cnt=1.
REQ-027 gen_rst in IDLE, ENTRY or FULL SHALL clear the entry and go to IDLE.
REQ-028 Reserved codes 0xD-0xF SHALL be ignored entirely, including for the timeout restart.
REQ-029 key_valid=0 SHALL mean no key event, regardless of key_code.
REQ-030 The timeout counter SHALL be 27 bits wide.
REQ-031 The timeout counter SHALL reset to 0 on every accepted key event and on every state change, and SHALL count only in ENTRY or FULL.
REQ-032 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-033 When the timeout counter reaches TIMEOUT_CYC-1, the next state SHALL be IDLE with the entry cleared.
REQ-034 A key event in the same cycle as the timeout SHALL take precedence, and the timeout SHALL restart.
REQ-035 disable_cnt SHALL equal the inverse of enough at all times.

Reset
REQ-036 rst_n=0 SHALL immediately (without waiting for a clock edge) force state=IDLE, pw_16bit=0, digit_cnt=0, enough=0, disable_cnt=1 and timeout counter=0.
REQ-037 After rst_n deasserts, the first key_valid strobe sampled SHALL be processed normally.
REQ-038 Reset asserted mid-entry or in SUBMIT SHALL discard all state.

Verification
REQ-039 Scenario: keys 1,2,3,4 then enter -> pw_16bit=0x1234, digit_cnt=4, then enough=1 and disable_cnt=0 one cycle after the enter strobe.
REQ-040 Scenario: 1,2,3,4,5 -> pw_16bit=0x1234 (fifth digit ignored); backspace, then 9 -> pw_16bit=0x1239.
REQ-041 Scenario: 5,6 then enter -> pw_16bit=0, digit_cnt=0, enough never asserted; then 7 with TIMEOUT_CYC=16 and no further keys -> cleared to IDLE exactly 16 cycles after the 7 strobe.
REQ-042 Scenario: in SUBMIT with 0x4321, keys 8, clear and backspace -> no change; then gen_rst pulse -> pw_16bit=0, enough=0 next cycle.
REQ-043 Scenario: gen_stop=1 during entry 0x0012 -> cleared next cycle and keys ignored for 10 cycles; gen_stop=0 -> IDLE; key 3 -> pw_16bit=0x0003.
REQ-044 Scenario: rst_n pulled low between clock edges while in FULL -> outputs at reset values before the next clock edge.
